// File: rtl/tr_drive_multi.sv
// Multi-channel tracking drive controller.
// Each channel maps a signed position error to a target step period. It then
// ramps its step period toward that target, limited to acc per step, and
// decelerates to n_max before it stops or reverses direction.

// Per-channel lane: two-stage error-to-period map plus step generator FSM.
module tr_drive_lane #(
  parameter int XW = 36,
  parameter int NW = 17,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dv_en_i,
  input  logic          en_i,
  input  logic [XW-1:0] x_i,
  input  logic [XW-1:0] x0_i,
  input  logic [XW-1:0] dx1_i,
  input  logic [XW-1:0] dx2_i,
  input  logic [NW-1:0] n_max_i,
  input  logic [NW-1:0] n_min_i,
  input  logic [NW-1:0] k_i,
  input  logic [NW-1:0] acc_i,
  output logic          step_o,
  output logic          dir_o,
  output logic          ena_o,
  output logic [NW-1:0] n_o
);

  localparam logic [XW-1:0] XMIN = {1'b1, {(XW-1){1'b0}}};
  localparam logic [XW-1:0] XMAX = {1'b0, {(XW-1){1'b1}}};

  typedef struct packed {
    logic [NW-1:0] tgt;
    logic          sgn;
    logic          dead;
  } req_t;

  typedef enum logic [1:0] {IDLE, RUN, DECEL} st_e;

  // ---------------- mapping pipeline ----------------
  logic [XW-1:0]    mag_d, s1_mag_q;
  logic             sgn_d, s1_sgn_q, dead_d, s1_dead_q, s1_vld_q;
  logic [XW-1:0]    dd;
  logic [NW+XW-1:0] prod;
  logic [NW-1:0]    span, tgt_d;
  req_t             req_q;

  // Stage 1 combinational: |x| with saturation of the most negative code.
  always_comb begin
    mag_d  = x_i[XW-1] ? (~x_i + XW'(1)) : x_i;
    if (x_i == XMIN) mag_d = XMAX;
    sgn_d  = ~x_i[XW-1] & (|x_i);
    dead_d = (mag_d <= x0_i);
  end

  // Stage 2 combinational: linear region with clamp, full-width product.
  always_comb begin
    dd    = '0;
    if (s1_mag_q > dx1_i) dd = ((s1_mag_q < dx2_i) ? s1_mag_q : dx2_i) - dx1_i;
    prod  = {{XW{1'b0}}, k_i} * {{NW{1'b0}}, dd};
    span  = n_max_i - n_min_i;
    tgt_d = (prod >= {{XW{1'b0}}, span}) ? n_min_i : (n_max_i - prod[NW-1:0]);
  end

  // Pipeline registers; reset leaves the request dead so nothing starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s1_mag_q  <= '0;
      s1_sgn_q  <= 1'b0;
      s1_dead_q <= 1'b1;
      req_q     <= '{tgt: '0, sgn: 1'b0, dead: 1'b1};
    end else begin
      s1_vld_q <= dv_en_i;
      if (dv_en_i) begin
        s1_mag_q  <= mag_d;
        s1_sgn_q  <= sgn_d;
        s1_dead_q <= dead_d;
      end
      if (s1_vld_q) req_q <= '{tgt: tgt_d, sgn: s1_sgn_q, dead: s1_dead_q};
    end
  end

  // ---------------- step generator ----------------
  st_e           st_q, st_d;
  logic [NW-1:0] per_q, per_d, cnt_q, cnt_d, eff_tgt, nxt;
  logic          dir_q, dir_d, go_decel, bnd;
  logic [NW:0]   up, lo_lim;

  // Ramp one step toward the effective target at NW+1 bits, clamped to it.
  always_comb begin
    go_decel = req_q.dead | (req_q.sgn != dir_q) | ~en_i;
    bnd      = (cnt_q == per_q - NW'(1));
    eff_tgt  = ((st_q == DECEL) || go_decel) ? n_max_i : req_q.tgt;
    up       = {1'b0, per_q} + {1'b0, acc_i};
    lo_lim   = {1'b0, eff_tgt} + {1'b0, acc_i};
    nxt      = per_q;
    if (per_q < eff_tgt)
      nxt = (up >= {1'b0, eff_tgt}) ? eff_tgt : up[NW-1:0];
    else if (per_q > eff_tgt)
      nxt = ({1'b0, per_q} <= lo_lim) ? eff_tgt : (per_q - acc_i);
  end

  // Next-state logic: period only changes at a period boundary.
  always_comb begin
    st_d  = st_q;
    per_d = per_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    case (st_q)
      IDLE: if (en_i && !req_q.dead) begin
        st_d  = RUN;
        per_d = n_max_i;
        cnt_d = '0;
        dir_d = req_q.sgn;
      end
      RUN: begin
        if (go_decel) st_d = DECEL;
        if (bnd) begin
          cnt_d = '0;
          per_d = nxt;
        end else cnt_d = cnt_q + NW'(1);
      end
      DECEL: begin
        if (bnd) begin
          cnt_d = '0;
          per_d = nxt;
          if (nxt == n_max_i) st_d = IDLE;
        end else cnt_d = cnt_q + NW'(1);
      end
      default: st_d = IDLE;
    endcase
  end

  // Generator state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      per_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      per_q <= per_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Step is decoded from registers so an async reset drops it at once.
  assign step_o = (st_q != IDLE) && (cnt_q < NW'(PW));
  assign ena_o  = (st_q != IDLE);
  assign dir_o  = dir_q;
  assign n_o    = per_q;

endmodule

// Top: CH independent lanes sharing the config inputs.
module tr_drive_multi #(
  parameter int CH = 2,
  parameter int XW = 36,
  parameter int NW = 17,
  parameter int PW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             tr_mode_enable,
  input  logic [CH*XW-1:0] x,
  input  logic [XW-1:0]    x0,
  input  logic [XW-1:0]    dx1,
  input  logic [XW-1:0]    dx2,
  input  logic [NW-1:0]    n_max,
  input  logic [NW-1:0]    n_min,
  input  logic [NW-1:0]    k,
  input  logic [NW-1:0]    acc,
  output logic [CH-1:0]    drv_step,
  output logic [CH-1:0]    drv_dir,
  output logic [CH-1:0]    drv_enable_SM,
  output logic [CH*NW-1:0] N
);

  logic dv_en;
  assign dv_en = data_valid & tr_mode_enable;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    tr_drive_lane #(.XW(XW), .NW(NW), .PW(PW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .dv_en_i (dv_en),
      .en_i    (tr_mode_enable),
      .x_i     (x[c*XW +: XW]),
      .x0_i    (x0),
      .dx1_i   (dx1),
      .dx2_i   (dx2),
      .n_max_i (n_max),
      .n_min_i (n_min),
      .k_i     (k),
      .acc_i   (acc),
      .step_o  (drv_step[c]),
      .dir_o   (drv_dir[c]),
      .ena_o   (drv_enable_SM[c]),
      .n_o     (N[c*NW +: NW])
    );
  end

endmodule

// File: tb/tb_tr_drive_multi.sv
// Bench for tr_drive_multi: directed scenarios plus random phases, all
// checked every cycle against a behavioural per-channel drive model.
module tb_tr_drive_multi;
  localparam int CH = 2, XW = 36, NW = 17, PW = 4;

  logic clk = 0, rst = 0, data_valid = 0, tr_mode_enable = 0;
  logic [CH*XW-1:0] x = '0;
  logic [XW-1:0]    x0, dx1, dx2;
  logic [NW-1:0]    n_max, n_min, k, acc;
  logic [CH-1:0]    drv_step, drv_dir, drv_enable_SM;
  logic [CH*NW-1:0] N;

  int n_tests = 0, n_fail = 0;

  always #10 clk = ~clk;

  tr_drive_multi #(.CH(CH), .XW(XW), .NW(NW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .tr_mode_enable(tr_mode_enable),
    .x(x), .x0(x0), .dx1(dx1), .dx2(dx2), .n_max(n_max), .n_min(n_min),
    .k(k), .acc(acc), .drv_step(drv_step), .drv_dir(drv_dir),
    .drv_enable_SM(drv_enable_SM), .N(N));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per channel: running?, braking?, period, cycles since last step start.
  bit     m_act[CH], m_brk[CH], m_dir[CH], m_rsgn[CH], m_rdead[CH], m_s1v;
  int     m_per[CH], m_el[CH], m_rtgt[CH];
  longint m_s1x[CH];

  function automatic longint mag_of(longint v);
    if (v == -(longint'(1) << (XW-1))) return (longint'(1) << (XW-1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int tgt_of(longint v);
    longint m, dd, prod, lo, hi;
    m  = mag_of(v);
    lo = longint'(dx1);
    hi = longint'(dx2);
    dd = (m <= lo) ? 0 : (((m < hi) ? m : hi) - lo);
    prod = longint'(k) * dd;
    if (prod >= longint'(n_max) - longint'(n_min)) return int'(n_min);
    return int'(longint'(n_max) - prod);
  endfunction

  function automatic int approach(int p, int t, int a);
    if (p < t) return (p + a >= t) ? t : p + a;
    if (p > t) return (p - a <= t) ? t : p - a;
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_act[c] = 0; m_brk[c] = 0; m_dir[c] = 0; m_per[c] = 0; m_el[c] = 0;
      m_rtgt[c] = 0; m_rsgn[c] = 0; m_rdead[c] = 1;
    end
    m_s1v = 0;
  endtask

  // One clock edge of the model, using the inputs the DUT sampled.
  task automatic model_edge();
    if (!rst) begin model_reset(); return; end
    for (int c = 0; c < CH; c++) begin
      if (!m_act[c]) begin
        if (tr_mode_enable && !m_rdead[c]) begin
          m_act[c] = 1; m_brk[c] = 0; m_per[c] = int'(n_max); m_el[c] = 0;
          m_dir[c] = m_rsgn[c];
        end
      end else begin
        bit stop, brk_now;
        int np;
        stop    = m_rdead[c] || (m_rsgn[c] != m_dir[c]) || !tr_mode_enable;
        brk_now = m_brk[c] || stop;
        if (m_el[c] == m_per[c] - 1) begin
          np = approach(m_per[c], brk_now ? int'(n_max) : m_rtgt[c], int'(acc));
          if (m_brk[c] && np == int'(n_max)) m_act[c] = 0;
          m_per[c] = np;
          m_el[c]  = 0;
        end else m_el[c]++;
        m_brk[c] = brk_now;
      end
    end
    if (m_s1v)
      for (int c = 0; c < CH; c++) begin
        m_rtgt[c]  = tgt_of(m_s1x[c]);
        m_rsgn[c]  = (m_s1x[c] > 0);
        m_rdead[c] = (mag_of(m_s1x[c]) <= longint'(x0));
      end
    m_s1v = data_valid && tr_mode_enable;
    if (m_s1v)
      for (int c = 0; c < CH; c++) begin
        logic signed [XW-1:0] xs;
        xs = x[c*XW +: XW];
        m_s1x[c] = longint'(xs);
      end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++)
      chk($sformatf("cycle_ch%0d", c),
          64'({drv_step[c], drv_enable_SM[c], drv_dir[c], N[c*NW +: NW]}),
          64'({(m_act[c] && m_el[c] < PW), m_act[c], m_dir[c], NW'(m_per[c])}));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic send(longint a, longint b);
    x = {b[XW-1:0], a[XW-1:0]};
    data_valid = 1;
    tick();
    data_valid = 0;
  endtask

  task automatic wait_idle(int max);
    int i = 0;
    while ((m_act[0] || m_act[1]) && i < max) begin tick(); i++; end
    chk("idle_wait", 64'(drv_enable_SM), 64'd0);
  endtask

  function automatic longint rand_x();
    longint v;
    case ($urandom_range(0, 4))
      0: v = $urandom_range(0, 10);
      1: v = $urandom_range(15, 50);
      2: v = $urandom_range(0, 2000);
      3: return -(longint'(1) << (XW-1));
      default: begin
        v = {28'd0, 4'($urandom()), 32'($urandom())};
        return (v >= (longint'(1) << (XW-1))) ? v - (longint'(1) << XW) : v;
      end
    endcase
    return $urandom_range(0, 1) ? -v : v;
  endfunction

  initial begin
    x0 = 5; dx1 = 250; dx2 = 555; n_max = 1000; n_min = 100; k = 2; acc = 50;
    model_reset();
    run(3);
    chk("reset_outs", 64'({drv_step, drv_enable_SM, drv_dir, N}), 64'd0);
    rst = 1;
    tr_mode_enable = 1;

    // Ramp and hold: ch0 +300 -> 900, ch1 at zero error stays idle.
    send(300, 0);
    run(4500);
    chk("hold_N0", 64'(N[NW-1:0]), 64'd900);
    chk("hold_dir0", 64'(drv_dir[0]), 64'd1);
    chk("hold_ch1", 64'({drv_step[1], drv_enable_SM[1], drv_dir[1], N[NW +: NW]}), 64'd0);

    // Dead zone: decelerate through 950, 1000 and stop.
    send(3, 0);
    run(3200);
    chk("dead_en0", 64'(drv_enable_SM[0]), 64'd0);
    chk("dead_N0", 64'(N[NW-1:0]), 64'd1000);

    // Reversal.
    send(300, 0);
    run(4500);
    send(-300, 0);
    run(3200);
    chk("rev_dir0", 64'(drv_dir[0]), 64'd0);
    chk("rev_en0", 64'(drv_enable_SM[0]), 64'd1);

    // Clamp in linear region end: tgt 390.
    send(-700, 0);
    run(9000);
    chk("clamp_N0", 64'(N[NW-1:0]), 64'd390);

    // Graceful stop on permit drop.
    tr_mode_enable = 0;
    wait_idle(20000);

    // k=1000 and saturated most-negative error: both to n_min.
    k = 1000;
    tr_mode_enable = 1;
    send(260, -(longint'(1) << (XW-1)));
    run(11500);
    chk("sat_N0", 64'(N[NW-1:0]), 64'd100);
    chk("sat_N1", 64'(N[NW +: NW]), 64'd100);
    chk("sat_dir", 64'(drv_dir), 64'd1);

    // Async reset during a step pulse.
    begin
      int i = 0;
      while (!drv_step[0] && i < 300) begin tick(); i++; end
      chk("pulse_seen", 64'(drv_step[0]), 64'd1);
    end
    rst = 0;
    #1;
    model_reset();
    chk("rst_async", 64'({drv_step, drv_enable_SM, drv_dir, N}), 64'd0);
    run(2);
    rst = 1;
    run(300);
    chk("no_restart", 64'(drv_enable_SM), 64'd0);

    // Random phases with a short-period config.
    x0 = 5; dx1 = 20; dx2 = 40; n_max = 60; n_min = 8;
    k = NW'($urandom_range(1, 4));
    acc = NW'($urandom_range(1, 15));
    for (int ph = 0; ph < 40; ph++) begin
      if ($urandom_range(0, 5) == 0) tr_mode_enable = ~tr_mode_enable;
      if ($urandom_range(0, 3) != 0) send(rand_x(), rand_x());
      run($urandom_range(20, 600));
    end
    tr_mode_enable = 0;
    wait_idle(5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tr_drive_multi.md
# tr_drive_multi

Parametrised multi-channel tracking drive controller: converts per-channel signed position error samples from the ADC path into step/direction/enable commands for stepper drivers. Successor to the single-channel tracking + pulse pair. It merges error-to-period mapping and pulse generation into one block, and adds:
- CH independent channels;
- a dead-zone / linear / clamped period map;
- acceleration-limited period ramping;
- controlled deceleration before stopping or reversing direction.

## Interface
Parameters:
- CH, 2, number of independent drive channels
- XW, 36, error sample width (signed two's complement)
- NW, 17, step period width in clk cycles
- PW, 4, drv_step high time in clk cycles; must be < n_min

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-low reset
- data_valid  in  1  one-cycle strobe: x valid for all channels
- tr_mode_enable  in  1  tracking permit; low = stop all channels gracefully
- x  in  CH*XW  signed error per channel, channel c at [c*XW +: XW]
- x0  in  XW  dead-zone half-width (unsigned)
- dx1, dx2  in  XW  start and end of linear region (unsigned), dx1 < dx2
- n_max  in  NW  slowest period (start/stop speed)
- n_min  in  NW  fastest period
- k  in  NW  period decrease per unit of error above dx1
- acc  in  NW  max period change per step, ≥ 1
- drv_step  out  CH  step pulse per channel
- drv_dir  out  CH  1 = positive error, 0 = negative
- drv_enable_SM  out  CH  driver enable per channel
- N  out  CH*NW  current step period per channel

## Operation
Mapping pipeline, per channel, runs only when data_valid=1 and tr_mode_enable=1:
- Stage 1:
  - mag = |x|; the most negative value saturates to 2^(XW-1)-1.
  - sgn = 1 if x > 0.
  - dead = (mag ≤ x0).
- Stage 2:
  - dd = 0 if mag ≤ dx1, else min(mag, dx2) − dx1.
  - prod = k*dd, full width NW+XW, no truncation.
  - tgt = n_min if prod ≥ n_max − n_min, else n_max − prod.
  - Register tgt, sgn and dead as the channel request.

Step generator, per channel, FSM states IDLE, RUN, DECEL:
- IDLE:
  - Outputs: drv_enable_SM=0, drv_step=0.
  - If tr_mode_enable=1 and the request is not dead: load period=n_max, cnt=0, drv_dir=sgn, go RUN.
- RUN:
  - drv_enable_SM=1.
  - cnt increments each cycle; drv_step=1 while cnt < PW.
  - Period boundary: when cnt = period−1, cnt←0 and period moves toward tgt by at most acc (never overshoots).
  - Go DECEL on any of: dead request, sgn ≠ drv_dir, or tr_mode_enable=0.
- DECEL:
  - Same pulse behaviour as RUN, but the effective target is n_max.
  - At a boundary where the updated period = n_max, go IDLE.
  - Returning to RUN requires passing through IDLE, so a reversal always starts at n_max with the new direction.
- Common to all states:
  - A new request while in RUN is used at the next boundary only; there is no mid-period reload.
  - Channels are fully independent and share only the config inputs.
- N always equals the period register.

## Timing
- Reset (rst=0, async): all outputs 0, state IDLE, period=0, cnt=0, requests cleared to dead.
- Request latency: data_valid at edge t → request registered at t+2; from IDLE, RUN is entered at t+3 and the first drv_step is high from t+3 for PW cycles.
- Step spacing equals the period in effect; consecutive steps are never closer than n_min or farther than n_max cycles once running.
- Config inputs are sampled continuously; software changes them only while all channels are IDLE.
- data_valid while tr_mode_enable=0: ignored, request unchanged.
- tr_mode_enable dropping mid-pulse: the current pulse completes its PW cycles, then the channel decelerates.
- rst asserted mid-pulse: drv_step drops immediately, asynchronously.
- Ramp arithmetic: period ± acc is computed at NW+1 bits and clamped to tgt, so there is no wrap-around.

## Test plan
Common config: CH=2, x0=5, dx1=250, dx2=555, n_max=1000, n_min=100, k=2, acc=50, PW=4.
- Ramp and hold: ch0 x=+300 → tgt 900; step spacings 1000, 950, 900, 900…; drv_dir=1, drv_enable_SM=1; ch1 (x=0) stays IDLE with all outputs 0.
- Clamp: x=−700 → dd clamped to 305, tgt 390, drv_dir=0, periods decrease by 50 per step down to 390. With k=1000 → tgt = n_min = 100.
- Dead zone: running at 900, then x=3 → periods 950, 1000, then drv_enable_SM=0 and no further steps.
- Reversal: running at 900 with x=+300, then x=−300 → decelerate to 1000, IDLE, then RUN with drv_dir=0 starting at period 1000.
- Enable and reset: tr_mode_enable=0 while running → decelerate to IDLE. rst=0 during a drv_step high → all outputs 0 the same cycle; after release, the channel restarts only after a new data_valid.
- Saturation: x=−2^35 → mag saturated, tgt 100, no overflow in prod.
